// File: rtl/dii_insn_src_if.sv
// ============================================================================
// dii_insn_src_if : stream-load and DII fetch handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface dii_insn_src_if;
  logic        ld_valid_i;
  logic [31:0] ld_insn_i;
  logic        ld_ready_o;
  logic [31:0] dii_insn_0_o;
  logic [31:0] dii_insn_1_o;
  logic [31:0] dii_pc_i;
  logic        dii_ack_0_i;
  logic        dii_ack_1_i;

  // master: the instruction source
  modport master (
    input  ld_valid_i, ld_insn_i, dii_pc_i, dii_ack_0_i, dii_ack_1_i,
    output ld_ready_o, dii_insn_0_o, dii_insn_1_o
  );

  // slave: the stream loader / core side
  modport slave (
    output ld_valid_i, ld_insn_i, dii_pc_i, dii_ack_0_i, dii_ack_1_i,
    input  ld_ready_o, dii_insn_0_o, dii_insn_1_o
  );
endinterface

`default_nettype wire

// File: rtl/dii_insn_src.sv
// ============================================================================
// dii_insn_src : circular DII instruction stream with fetch/retire pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module dii_insn_src #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] FILLER_INSN = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  dii_insn_src_if.master           bus,
  input  logic                     retire_i,
  input  logic                     rewind_i,
  output logic [31:0]              last_ack_pc_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [15:0]              starve_cnt_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, fe_q, fe_d, rt_q, rt_d;
  logic [31:0]   pc_q, pc_d;
  logic [15:0]   starve_q, starve_d;
  logic          err_q, err_d;

  logic [PW-1:0] occ;
  logic          ld_fire, empty, fe_adv, rt_ok;

  assign occ     = wr_q - rt_q;
  assign empty   = (fe_q == wr_q);
  assign ld_fire = bus.ld_valid_i & (occ != C_DEPTH);
  assign fe_adv  = bus.dii_ack_0_i & ~empty;
  assign rt_ok   = retire_i & (rt_q != fe_q);

  assign bus.ld_ready_o   = (occ != C_DEPTH);
  assign bus.dii_insn_0_o = empty ? FILLER_INSN : mem_q[fe_q[AW-1:0]];
  assign bus.dii_insn_1_o = FILLER_INSN;
  assign last_ack_pc_o    = pc_q;
  assign occupancy_o      = occ;
  assign starve_cnt_o     = starve_q;
  assign err_o            = err_q;

  always_comb begin
    wr_d     = wr_q + PW'(ld_fire);
    rt_d     = rt_q + PW'(rt_ok);
    fe_d     = fe_q + PW'(fe_adv);
    pc_d     = pc_q;
    starve_d = starve_q;
    err_d    = err_q;
    // rewind lands on the post-retire pointer so the trapping insn stays retired
    if (rewind_i) fe_d = rt_d;
    if (bus.dii_ack_0_i) begin
      pc_d = bus.dii_pc_i;
      if (empty && starve_q != 16'hFFFF) starve_d = starve_q + 16'd1;
    end
    if (bus.dii_ack_1_i || (retire_i && !rt_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q     <= '0;
      fe_q     <= '0;
      rt_q     <= '0;
      pc_q     <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      fe_q     <= fe_d;
      rt_q     <= rt_d;
      pc_q     <= pc_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // storage needs no reset; only pointer-covered slots are ever presented
  always_ff @(posedge clk_i) begin
    if (ld_fire) mem_q[wr_q[AW-1:0]] <= bus.ld_insn_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_dii_insn_src.sv
// ============================================================================
// tb_dii_insn_src : table vectors, directed corner sequences, random vs model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dii_insn_src;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] FILLER = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        retire_i = 1'b0, rewind_i = 1'b0;
  logic [31:0] last_ack_pc_o;
  logic [4:0]  occupancy_o;
  logic [15:0] starve_cnt_o;
  logic        err_o;

  dii_insn_src_if u_if ();

  dii_insn_src #(.DEPTH(DEPTH), .FILLER_INSN(FILLER)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .bus(u_if.master),
    .retire_i(retire_i), .rewind_i(rewind_i),
    .last_ack_pc_o(last_ack_pc_o), .occupancy_o(occupancy_o),
    .starve_cnt_o(starve_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: absolute counts into an ever-growing stream history
  logic [31:0] m_hist[$];
  int          m_ld, m_fe, m_rt;
  logic [31:0] m_pc;
  int          m_starve;
  logic        m_err;

  task automatic m_reset();
    m_hist.delete();
    m_ld = 0; m_fe = 0; m_rt = 0; m_pc = '0; m_starve = 0; m_err = 1'b0;
  endtask

  task automatic m_step(input logic ldv, input logic [31:0] ldw, input logic a0, input logic a1,
                        input logic [31:0] pc, input logic ret, input logic rew);
    int nrt, nfe;
    bit have;
    have = (m_fe < m_ld);
    nrt  = m_rt;
    if (ret) begin
      if (m_rt < m_fe) nrt = m_rt + 1;
      else m_err = 1'b1;
    end
    if (a1) m_err = 1'b1;
    if (a0) begin
      m_pc = pc;
      if (!have && m_starve < 65535) m_starve++;
    end
    nfe = rew ? nrt : m_fe + ((a0 && have) ? 1 : 0);
    if (ldv && (m_ld - m_rt) != DEPTH) begin
      m_hist.push_back(ldw);
      m_ld++;
    end
    m_rt = nrt;
    m_fe = nfe;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("insn0", u_if.dii_insn_0_o, (m_fe < m_ld) ? m_hist[m_fe] : FILLER);
    chk("insn1", u_if.dii_insn_1_o, FILLER);
    chk("ready", {31'd0, u_if.ld_ready_o}, {31'd0, (m_ld - m_rt) != DEPTH});
    chk("occ", {27'd0, occupancy_o}, 32'(m_ld - m_rt));
    chk("starve", {16'd0, starve_cnt_o}, 32'(m_starve));
    chk("err", {31'd0, err_o}, {31'd0, m_err});
    chk("lastpc", last_ack_pc_o, m_pc);
  endtask

  // inputs applied 1ns after an edge, outputs compared 1ns after the next
  task automatic cycle(input logic ldv, input logic [31:0] ldw, input logic a0, input logic a1,
                       input logic [31:0] pc, input logic ret, input logic rew);
    u_if.ld_valid_i  = ldv; u_if.ld_insn_i  = ldw;
    u_if.dii_ack_0_i = a0;  u_if.dii_ack_1_i = a1; u_if.dii_pc_i = pc;
    retire_i = ret; rewind_i = rew;
    @(posedge clk);
    m_step(ldv, ldw, a0, a1, pc, ret, rew);
    #1;
    u_if.ld_valid_i = 1'b0; u_if.dii_ack_0_i = 1'b0; u_if.dii_ack_1_i = 1'b0;
    retire_i = 1'b0; rewind_i = 1'b0;
    chk_model();
  endtask

  task automatic load(input logic [31:0] w);  cycle(1, w, 0, 0, 0, 0, 0); endtask
  task automatic ack(input logic [31:0] pc);  cycle(0, 0, 1, 0, pc, 0, 0); endtask
  task automatic retire();                    cycle(0, 0, 0, 0, 0, 1, 0); endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_insn0"}, u_if.dii_insn_0_o, FILLER);
    chk({tag, "_insn1"}, u_if.dii_insn_1_o, FILLER);
    chk({tag, "_ready"}, {31'd0, u_if.ld_ready_o}, 32'd1);
    chk({tag, "_occ"}, {27'd0, occupancy_o}, 32'd0);
    chk({tag, "_starve"}, {16'd0, starve_cnt_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
    chk({tag, "_pc"}, last_ack_pc_o, 32'd0);
  endtask

  // asserted mid-cycle; outputs must clear without waiting for an edge
  task automatic do_reset(input string tag);
    rstn_i = 1'b0;
    #1;
    chk_reset_vals(tag);
    m_reset();
    @(posedge clk); #1;
    rstn_i = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        ldv;
    logic [31:0] ldw;
    logic        a0;
    logic [31:0] pc;
    logic        ret;
    logic [31:0] e_insn;
    logic        e_ready;
    int          e_occ;
    int          e_starve;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic ldv, logic [31:0] ldw, logic a0, logic [31:0] pc, logic ret,
                              logic [31:0] ei, logic er, int eo, int es, logic [31:0] ep);
    vec_t v;
    v.ldv = ldv; v.ldw = ldw; v.a0 = a0; v.pc = pc; v.ret = ret;
    v.e_insn = ei; v.e_ready = er; v.e_occ = eo; v.e_starve = es; v.e_pc = ep;
    return v;
  endfunction

  initial begin
    logic [31:0] w [5];
    u_if.ld_valid_i = 0; u_if.ld_insn_i = 0; u_if.dii_ack_0_i = 0;
    u_if.dii_ack_1_i = 0; u_if.dii_pc_i = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rstn_i = 1'b1;
    @(posedge clk); #1;

    // empty acks, then sequential feed, retire-to-empty, load+ack while empty
    tbl[0]  = mk(0, 0,            1, 32'h10,  0, FILLER,       1, 0, 1, 32'h10);
    tbl[1]  = mk(0, 0,            1, 32'h14,  0, FILLER,       1, 0, 2, 32'h14);
    tbl[2]  = mk(0, 0,            1, 32'h18,  0, FILLER,       1, 0, 3, 32'h18);
    tbl[3]  = mk(1, 32'h11111111, 0, 0,       0, 32'h11111111, 1, 1, 3, 32'h18);
    tbl[4]  = mk(1, 32'h22222222, 0, 0,       0, 32'h11111111, 1, 2, 3, 32'h18);
    tbl[5]  = mk(1, 32'h33333333, 0, 0,       0, 32'h11111111, 1, 3, 3, 32'h18);
    tbl[6]  = mk(0, 0,            1, 32'h100, 0, 32'h22222222, 1, 3, 3, 32'h100);
    tbl[7]  = mk(0, 0,            1, 32'h104, 0, 32'h33333333, 1, 3, 3, 32'h104);
    tbl[8]  = mk(0, 0,            1, 32'h108, 0, FILLER,       1, 3, 3, 32'h108);
    tbl[9]  = mk(0, 0,            0, 0,       1, FILLER,       1, 2, 3, 32'h108);
    tbl[10] = mk(0, 0,            0, 0,       1, FILLER,       1, 1, 3, 32'h108);
    tbl[11] = mk(0, 0,            0, 0,       1, FILLER,       1, 0, 3, 32'h108);
    tbl[12] = mk(1, 32'hAAAA0001, 1, 32'h10C, 0, 32'hAAAA0001, 1, 1, 4, 32'h10C);
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].ldv, tbl[i].ldw, tbl[i].a0, 1'b0, tbl[i].pc, tbl[i].ret, 1'b0);
      chk("tbl_insn0", u_if.dii_insn_0_o, tbl[i].e_insn);
      chk("tbl_ready", {31'd0, u_if.ld_ready_o}, {31'd0, tbl[i].e_ready});
      chk("tbl_occ", {27'd0, occupancy_o}, 32'(tbl[i].e_occ));
      chk("tbl_starve", {16'd0, starve_cnt_o}, 32'(tbl[i].e_starve));
      chk("tbl_pc", last_ack_pc_o, tbl[i].e_pc);
      chk("tbl_err", {31'd0, err_o}, 32'd0);
    end

    // full buffer: 17th load dropped, freed slot visible the cycle after retire
    do_reset("rst_full");
    for (int i = 0; i < DEPTH; i++) load(32'hF000_0000 + 32'(i));
    chk("full_ready", {31'd0, u_if.ld_ready_o}, 32'd0);
    load(32'hDEAD_BEEF);
    chk("full_drop_occ", {27'd0, occupancy_o}, 32'd16);
    ack(32'h200);
    retire();
    chk("full_free_ready", {31'd0, u_if.ld_ready_o}, 32'd1);
    chk("full_free_occ", {27'd0, occupancy_o}, 32'd15);
    chk("full_insn0", u_if.dii_insn_0_o, 32'hF000_0001);

    // trap rewind: retire+rewind on B re-feeds C, D, E
    do_reset("rst_trap");
    for (int i = 0; i < 5; i++) begin
      w[i] = 32'hA000_0000 + 32'(i);
      load(w[i]);
    end
    for (int i = 0; i < 4; i++) ack(32'h300 + 32'(4 * i));
    retire();
    cycle(0, 0, 0, 0, 0, 1, 1);
    chk("trap_insn0", u_if.dii_insn_0_o, w[2]);
    ack(32'h308);
    chk("trap_refeed_d", u_if.dii_insn_0_o, w[3]);
    ack(32'h30C);
    chk("trap_refeed_e", u_if.dii_insn_0_o, w[4]);
    ack(32'h310);
    chk("trap_drained", u_if.dii_insn_0_o, FILLER);
    chk("trap_occ", {27'd0, occupancy_o}, 32'd3);

    // rewind overrides a same-cycle ack but the PC is still captured
    do_reset("rst_rwack");
    for (int i = 0; i < 5; i++) load(w[i]);
    for (int i = 0; i < 3; i++) ack(32'h400 + 32'(4 * i));
    retire();
    cycle(0, 0, 1, 0, 32'h40C, 0, 1);
    chk("rwack_insn0", u_if.dii_insn_0_o, w[1]);
    chk("rwack_pc", last_ack_pc_o, 32'h40C);

    // protocol errors and mid-stream reset
    do_reset("rst_err");
    load(32'h5555_0000);
    retire();
    chk("err_bad_retire", {31'd0, err_o}, 32'd1);
    chk("err_rt_unchanged", {27'd0, occupancy_o}, 32'd1);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("err_ack1", {31'd0, err_o}, 32'd1);
    chk("err_ack1_insn0", u_if.dii_insn_0_o, 32'h5555_0000);
    ack(32'h500);
    do_reset("rst_mid");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic ret;
      ret = (m_rt < m_fe) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
      cycle($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 400) == 0, $urandom, ret, $urandom_range(0, 30) == 0);
      if (i == 1500) do_reset("rst_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dii_insn_src.md
Name: dii_insn_src

Overview:
- Instruction source for the DII (direct instruction injection) fetch path of the cheriot-ibex DV bench.
- It is the generator end of the DII protocol. It drives `dii_insn_0`/`dii_insn_1` into the core's prefetch FIFO injection point and consumes the core's `dii_ack` and `dii_pc` handshake.
- It holds a loadable circular instruction stream and tracks two pointers:
  - fetched: acked by the core;
  - retired: confirmed by retirement feedback.
- It can rewind fetch to the oldest unretired entry, so a trap flush re-feeds squashed instructions.

Parameters:
- Depth, 16, stream buffer entries; power of two, ≥ 4.
- FillerInsn, 32'h0000_0013, word presented when no unfetched entry exists (`addi x0,x0,0`).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- ld_valid_i  in  1  stream load request
- ld_insn_i  in  32  instruction word to append
- ld_ready_o  out  1  buffer can accept a load this cycle
- dii_insn_0_o  out  32  instruction presented on DII port 0
- dii_insn_1_o  out  32  instruction presented on DII port 1; constant FillerInsn
- dii_pc_i  in  32  PC of the instruction being acked
- dii_ack_0_i  in  1  core consumed `dii_insn_0_o` this cycle
- dii_ack_1_i  in  1  core consumed `dii_insn_1_o`; unsupported, flagged
- retire_i  in  1  one fetched instruction retired (driven from `rvfi_valid`)
- rewind_i  in  1  discard fetched-unretired entries and re-feed them (driven from a retiring `rvfi_trap`)
- last_ack_pc_o  out  32  PC captured at the most recent accepted ack_0
- occupancy_o  out  $clog2(Depth)+1  entries written and not yet retired
- starve_cnt_o  out  16  acks taken while empty; saturating
- err_o  out  1  sticky protocol error

Behaviour:
- Pointers `wr_ptr`, `fe_ptr`, `rt_ptr` are $clog2(Depth)+1 bits wide.
  - The MSB is a wrap bit; the index is the low bits.
  - Invariant: rt_ptr ≤ fe_ptr ≤ wr_ptr (modular).
- Reset, asynchronous on rstn_i low:
  - all pointers 0, storage contents don't-care;
  - ld_ready_o=1, dii_insn_0_o=FillerInsn, dii_insn_1_o=FillerInsn;
  - last_ack_pc_o=0, occupancy_o=0, starve_cnt_o=0, err_o=0.
  - Reset mid-stream discards everything; there is no partial state.
- Load:
  - ld_ready_o = (wr_ptr − rt_ptr) != Depth, combinational from registered pointers.
  - ld_valid_i & ld_ready_o writes `mem[wr_ptr]` and increments wr_ptr at the clock edge.
  - ld_valid_i while full: ignored, no error.
  - Retired slots become free the cycle after the retire.
- Present:
  - dii_insn_0_o = (fe_ptr != wr_ptr) ? mem[fe_ptr] : FillerInsn, combinational from registered state.
  - A word loaded at edge N is visible after edge N. The load-to-present latency is 1 cycle when the buffer was empty.
- Ack:
  - dii_ack_0_i with an entry available: fe_ptr+1 and last_ack_pc_o ← dii_pc_i.
  - dii_ack_0_i while empty: fe_ptr unchanged, starve_cnt_o+1 (saturating at 16'hFFFF), last_ack_pc_o still updated.
  - dii_ack_1_i: err_o ← 1; no pointer change.
- Retire:
  - retire_i with rt_ptr != fe_ptr: rt_ptr+1.
  - retire_i with rt_ptr == fe_ptr: err_o ← 1, ignored.
- Rewind: rewind_i sets fe_ptr_next = rt_ptr_next.
  - rt_ptr_next includes a same-cycle retire, so the trapping instruction counts as retired.
  - Rewind overrides a same-cycle ack_0: that ack does not advance fe_ptr, but last_ack_pc_o still updates.
- Same-cycle events:
  - Load + retire + ack in one cycle are independent and all take effect.
  - Load in the same cycle as a rewind is accepted normally.
- occupancy_o = wr_ptr − rt_ptr, registered-pointer derived.
- err_o clears only on reset.

Test Plan:
- Sequential feed: load 0x11111111, 0x22222222, 0x33333333, then ack_0 each cycle with pc 0x100/0x104/0x108 -> dii_insn_0_o shows the three words in order, then FillerInsn; last_ack_pc_o=0x108.
- Empty ack: no loads, 3 ack_0 -> dii_insn_0_o=0x00000013 throughout; starve_cnt_o=3; err_o=0.
- Full: load 16 words with no retire -> ld_ready_o=0 after the 16th and a 17th load is dropped. One ack plus one retire -> ld_ready_o=1 the next cycle and occupancy_o=15.
- Trap rewind: load A..E, ack A..D, retire A, then retire+rewind on B -> next presented word is C; acks re-deliver C, D, E; occupancy_o=3.
- Rewind with same-cycle ack: fe at D, ack_0 and rewind together with rt at B -> fe_ptr=B's index, dii_insn_0_o=B next cycle.
- Errors: retire with nothing fetched -> err_o=1, rt_ptr unchanged. Pulse dii_ack_1_i -> err_o stays 1. Assert rstn_i low mid-stream -> all outputs return to reset values immediately.
